// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one external ALU among NUM_REQ requesters.
// Optional completed-op counter (op_count port) is enabled by defining ALU_ARB_CNT_EN.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [2*NUM_REQ-1:0]        req_opcode,
  input  logic [DATA_W*NUM_REQ-1:0]   req_a,
  input  logic [DATA_W*NUM_REQ-1:0]   req_b,
  output logic [1:0]                  alu_opcode,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  input  logic [DATA_W-1:0]           alu_y,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_W-1:0]           rsp_y,
`ifdef ALU_ARB_CNT_EN
  output logic [15:0]                 op_count,
`endif
  output logic [1:0]                  dbg_state
);

  // Handshakes: a transfer occurs on a rising edge where valid && ready are both high.
  // Request side: ready is combinational from valid; requesters hold payload until ready.
  // Response side: rsp_valid/rsp_id/rsp_y stay stable until rsp_ready is seen.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_gid;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_y;
  logic                w_any;
  logic [ID_W-1:0]     w_grant;
  logic [NUM_REQ-1:0]  w_req_ready;

  // Scan from the highest offset down so the last hit is the one closest to rr_ptr.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    w_any   = 1'b0;
    w_grant = '0;
    v_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req_valid[v_idx]) begin
        w_any   = 1'b1;
        w_grant = v_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_req_ready[w_grant] = 1'b1;
          w_next               = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_gid       <= '0;
      r_op        <= 2'b00;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gid <= w_grant;
            r_op  <= req_opcode[2*int'(w_grant) +: 2];
            r_a   <= req_a[DATA_W*int'(w_grant) +: DATA_W];
            r_b   <= req_b[DATA_W*int'(w_grant) +: DATA_W];
          end
        end
        ST_ISSUE: begin
          r_rsp_y     <= alu_y;
          r_rsp_id    <= r_gid;
          r_rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= ID_W'((int'(r_gid) + 1) % NUM_REQ);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_CNT_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_op_count <= 16'h0000;
    else if (r_state == ST_RESP && rsp_ready)      r_op_count <= r_op_count + 16'h0001;
  end

  assign op_count = r_op_count;
`endif

  // ALU operands come straight from the latch registers, so they hold outside ISSUE.
  assign alu_opcode = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign req_ready  = w_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_y      = r_rsp_y;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU on the alu_* port.
// Build with +define+ALU_ARB_CNT_EN to also exercise the op_count wrap.
module tb_alu_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [2*NUM_REQ-1:0]       req_opcode;
  logic [DATA_W*NUM_REQ-1:0]  req_a;
  logic [DATA_W*NUM_REQ-1:0]  req_b;
  logic [1:0]                 alu_opcode;
  logic [DATA_W-1:0]          alu_a;
  logic [DATA_W-1:0]          alu_b;
  logic [DATA_W-1:0]          alu_y;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [DATA_W-1:0]          rsp_y;
  logic [1:0]                 dbg_state;
`ifdef ALU_ARB_CNT_EN
  logic [15:0]                op_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [ID_W+DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ref_alu(input logic [1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return ~a;
      default: return a | b;
    endcase
  endfunction

  assign alu_y = ref_alu(alu_opcode, alu_a, alu_b);

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
`ifdef ALU_ARB_CNT_EN
    .op_count   (op_count),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_valid[i]                = 1'b1;
    req_opcode[2*i +: 2]        = op;
    req_a[DATA_W*i +: DATA_W]   = a;
    req_b[DATA_W*i +: DATA_W]   = b;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    tests_run++;
    if ({req_ready, rsp_valid, rsp_id, rsp_y, alu_opcode, alu_a, alu_b, dbg_state} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b v=%b id=%0d y=%h op=%b a=%h b=%h st=%0d required all 0",
               req_ready, rsp_valid, rsp_id, rsp_y, alu_opcode, alu_a, alu_b, dbg_state);
    end
`ifdef ALU_ARB_CNT_EN
    tests_run++;
    if (op_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_op_count: got %h required 0000", op_count);
    end
`endif
  endtask

  task automatic test_add_latency();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 2'b00, 8'h0F, 8'hF0);
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL add_ready_same_cycle: got %b required 0001", req_ready);
    end
    exp_q.push_back({2'd0, 8'hFF});
    @(negedge clk);
    req_valid = '0;
    tests_run++;
    if ({rsp_valid, req_ready, alu_opcode, alu_a, alu_b} !== {1'b0, 4'b0000, 2'b00, 8'h0F, 8'hF0}) begin
      tests_failed++;
      $display("FAIL add_issue_cycle: got v=%b rdy=%b op=%b a=%h b=%h required v=0 rdy=0000 op=00 a=0f b=f0",
               rsp_valid, req_ready, alu_opcode, alu_a, alu_b);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0 || {rsp_id, rsp_y} !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL add_rsp_t2: got v=%b id=%0d y=%h required v=1 id=0 y=ff", rsp_valid, rsp_id, rsp_y);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL add_rsp_done: got v=%b st=%0d required v=0 st=0", rsp_valid, dbg_state);
    end
  endtask

  task automatic test_sub_inv();
    int              ids[2] = '{1, 2};
    logic [1:0]      ops[2] = '{2'b01, 2'b10};
    logic [7:0]      as[2]  = '{8'h00, 8'h0F};
    logic [7:0]      bs[2]  = '{8'h01, 8'h3C};
    logic [7:0]      ys[2]  = '{8'hFF, 8'hF0};
    logic [ID_W+DATA_W-1:0] exp;
    bit              got;
    int              cyc;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_req(ids[k], ops[k], as[k], bs[k]);
      got = 0; cyc = 0;
      while (!got && cyc < 20) begin
        #1;
        if (|req_ready) begin
          tests_run++;
          if (req_ready !== (NUM_REQ'(1) << ids[k])) begin
            tests_failed++;
            $display("FAIL subinv_grant%0d: got %b required one-hot %0d", k, req_ready, ids[k]);
          end
          exp_q.push_back({ID_W'(ids[k]), ys[k]});
          got = 1;
        end
        @(negedge clk);
        cyc++;
      end
      req_valid = '0;
      if (!got) begin
        tests_run++; tests_failed++;
        $display("FAIL subinv_accept_timeout%0d: got no ready required ready within 20 cycles", k);
      end
      got = 0; cyc = 0;
      while (!got && cyc < 20) begin
        #1;
        if (rsp_valid) begin
          tests_run++;
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          if ({rsp_id, rsp_y} !== exp) begin
            tests_failed++;
            $display("FAIL subinv_rsp%0d: got id=%0d y=%h required id=%0d y=%h",
                     k, rsp_id, rsp_y, exp[DATA_W +: ID_W], exp[DATA_W-1:0]);
          end
          got = 1;
        end
        @(negedge clk);
        cyc++;
      end
      if (!got) begin
        tests_run++; tests_failed++;
        $display("FAIL subinv_rsp_timeout%0d: got no rsp_valid required within 20 cycles", k);
      end
    end
  endtask

  task automatic test_round_robin();
    int   exp_grant;
    int   grants;
    int   cyc;
    int   refresh;
    bit   got;
    logic [ID_W+DATA_W-1:0] exp;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    exp_grant = 0; grants = 0; cyc = 0;
    while (grants < 5 && cyc < 100) begin
      #1;
      refresh = -1;
      tests_run++;
      if ($countones(req_ready) > 1) begin
        tests_failed++;
        $display("FAIL rr_onehot: got %b required at most one bit", req_ready);
      end
      if (rsp_valid) begin
        tests_run++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if ({rsp_id, rsp_y} !== exp) begin
          tests_failed++;
          $display("FAIL rr_rsp: got id=%0d y=%h required id=%0d y=%h",
                   rsp_id, rsp_y, exp[DATA_W +: ID_W], exp[DATA_W-1:0]);
        end
      end
      if (|req_ready) begin
        tests_run++;
        if (req_ready !== (NUM_REQ'(1) << exp_grant)) begin
          tests_failed++;
          $display("FAIL rr_grant%0d: got %b required one-hot %0d", grants, req_ready, exp_grant);
        end
        exp_q.push_back({ID_W'(exp_grant),
                         ref_alu(req_opcode[2*exp_grant +: 2], req_a[DATA_W*exp_grant +: DATA_W],
                                 req_b[DATA_W*exp_grant +: DATA_W])});
        refresh   = exp_grant;
        exp_grant = (exp_grant + 1) % NUM_REQ;
        grants++;
      end
      @(negedge clk);
      if (refresh >= 0)
        set_req(refresh, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      cyc++;
    end
    req_valid = '0;
    if (grants < 5) begin
      tests_run++; tests_failed++;
      $display("FAIL rr_timeout: got %0d grants required 5", grants);
    end
    got = 0; cyc = 0;
    while (!got && cyc < 10) begin
      #1;
      if (rsp_valid) begin
        tests_run++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if ({rsp_id, rsp_y} !== exp) begin
          tests_failed++;
          $display("FAIL rr_last_rsp: got id=%0d y=%h required id=%0d y=%h",
                   rsp_id, rsp_y, exp[DATA_W +: ID_W], exp[DATA_W-1:0]);
        end
        got = 1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!got) begin
      tests_run++; tests_failed++;
      $display("FAIL rr_last_rsp_timeout: got no rsp_valid required within 10 cycles");
    end
  endtask

  task automatic test_backpressure();
    bit   got;
    int   cyc;
    logic [ID_W+DATA_W-1:0] exp;
    rsp_ready = 1'b0;
    set_req(3, 2'b11, 8'hA5, 8'h0C);
    got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      #1;
      if (req_ready[3]) begin
        exp_q.push_back({2'd3, 8'hAD});
        got = 1;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    set_req(0, 2'b00, 8'h11, 8'h22);
    got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      #1;
      if (rsp_valid) got = 1;
      else @(negedge clk);
      cyc++;
    end
    if (!got) begin
      tests_run++; tests_failed++;
      $display("FAIL bp_rsp_timeout: got no rsp_valid required within 20 cycles");
    end
    exp = (exp_q.size() != 0) ? exp_q[0] : '1;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if ({rsp_valid, rsp_id, rsp_y, req_ready, dbg_state} !== {1'b1, exp, 4'b0000, 2'd2}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d y=%h rdy=%b st=%0d required v=1 id=%0d y=%h rdy=0000 st=2",
                 c, rsp_valid, rsp_id, rsp_y, req_ready, dbg_state, exp[DATA_W +: ID_W], exp[DATA_W-1:0]);
      end
      @(negedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tests_run++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    if (rsp_valid !== 1'b1 || {rsp_id, rsp_y} !== exp) begin
      tests_failed++;
      $display("FAIL bp_release: got v=%b id=%0d y=%h required v=1 id=%0d y=%h",
               rsp_valid, rsp_id, rsp_y, exp[DATA_W +: ID_W], exp[DATA_W-1:0]);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_after_hs: got v=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    bit   got;
    int   cyc;
    logic [ID_W+DATA_W-1:0] exp;
    rsp_ready = 1'b1;
    set_req(2, 2'b00, 8'h01, 8'h02);
    #1;
    @(negedge clk);
    req_valid = '0;
    tests_run++;
    if (dbg_state !== 2'd1) begin
      tests_failed++;
      $display("FAIL rstmid_in_issue: got st=%0d required 1", dbg_state);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, rsp_valid, rsp_id, rsp_y, alu_opcode, alu_a, alu_b, dbg_state} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got rdy=%b v=%b id=%0d y=%h op=%b a=%h b=%h st=%0d required all 0",
               req_ready, rsp_valid, rsp_id, rsp_y, alu_opcode, alu_a, alu_b, dbg_state);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b01, 8'(8'h40 + i), 8'h03);
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rstmid_first_grant: got %b required 0001", req_ready);
    end
    exp_q.push_back({2'd0, 8'h3D});
    @(negedge clk);
    req_valid = '0;
    got = 0; cyc = 0;
    while (!got && cyc < 10) begin
      #1;
      if (rsp_valid) begin
        tests_run++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if ({rsp_id, rsp_y} !== exp) begin
          tests_failed++;
          $display("FAIL rstmid_rsp: got id=%0d y=%h required id=%0d y=%h",
                   rsp_id, rsp_y, exp[DATA_W +: ID_W], exp[DATA_W-1:0]);
        end
        got = 1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!got) begin
      tests_run++; tests_failed++;
      $display("FAIL rstmid_rsp_timeout: got no rsp_valid required within 10 cycles");
    end
`ifdef ALU_ARB_CNT_EN
    tests_run++;
    if (op_count !== 16'h0001) begin
      tests_failed++;
      $display("FAIL rstmid_op_count: got %h required 0001", op_count);
    end
`endif
  endtask

`ifdef ALU_ARB_CNT_EN
  task automatic test_count_wrap();
    int cyc;
    force dut.r_op_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_op_count;
    #1;
    tests_run++;
    if (op_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL cnt_preload: got %h required ffff", op_count);
    end
    rsp_ready = 1'b1;
    set_req(1, 2'b00, 8'h01, 8'h01);
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    while (!rsp_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (op_count !== 16'h0000 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL cnt_wrap: got cnt=%h v=%b required cnt=0000 v=0", op_count, rsp_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add_latency();
    test_sub_inv();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
`ifdef ALU_ARB_CNT_EN
    test_count_wrap();
`endif
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
